// File: rtl/mem_bus_pkg.sv
// ----------------------------------------------------------------------------
// mem_bus_pkg
// Shared definitions for the byte-wide memory bus engine:
//   state_e   - engine FSM states
//   IO_HI     - default value of addr[17:16] that selects I/O space
//   LEN_*     - request length encodings (bytes)
//   addr_t    - 32-bit byte address
//   last_idx  - maps a length encoding to the index of its final byte
//   byte_sel  - extracts little-endian byte k of a 32-bit word
// ----------------------------------------------------------------------------
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD     = 2'd1,
      WR     = 2'd2,
      IOWAIT = 2'd3
   } state_e;

   localparam logic [1:0] IO_HI = 2'b11;

   localparam logic [2:0] LEN_B = 3'd1;
   localparam logic [2:0] LEN_H = 3'd2;
   localparam logic [2:0] LEN_W = 3'd4;

   typedef logic [31:0] addr_t;

   // Illegal lengths collapse to a single byte so the counters stay bounded.
   function automatic logic [1:0] last_idx(input logic [2:0] len);
      case (len)
         LEN_B:   return 2'd0;
         LEN_H:   return 2'd1;
         LEN_W:   return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
      return w[8*idx +: 8];
   endfunction

endpackage

// File: rtl/byte_bus_engine.sv
// ----------------------------------------------------------------------------
// byte_bus_engine
// Serializes one 1/2/4-byte load or store into byte-wide bus cycles.
// Loads are assembled little-endian; I/O stores wait on io_buffer_full.
// A low rdy freezes the engine without repeating or dropping bytes.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   rdy               global ready; low stalls the engine
//   req_valid/ready   request handshake (ready only while idle)
//   req_wr            1 = store, 0 = load
//   req_addr/len      byte address of byte 0, byte count (1, 2, 4)
//   req_wdata         store data, byte k in bits [8k+7:8k]
//   done, rdata       completion pulse, zero-extended load data
//   mem_din           RAM read byte (one cycle after its address)
//   mem_a/dout/wr     registered byte bus (mem_wr also gated by rdy)
//   io_buffer_full    UART TX buffer full
// ----------------------------------------------------------------------------
module byte_bus_engine #(
   parameter logic [1:0] IO_HI = mem_bus_pkg::IO_HI
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_len,
   input  logic [31:0] req_wdata,
   output logic        done,
   output logic [31:0] rdata,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);

   import mem_bus_pkg::*;

   state_e      state_q,     state_d;
   addr_t       addr_q,      addr_d;
   logic [31:0] wdata_q,     wdata_d;
   logic [1:0]  last_q,      last_d;
   logic        io_q,        io_d;
   logic [1:0]  issue_q,     issue_d;     // index of the byte on the bus
   logic [1:0]  capture_q,   capture_d;   // next read byte to capture
   logic        addr_vld_q,  addr_vld_d;  // bus holds a read address not yet issued
   logic        inflight_q,  inflight_d;  // mem_din carries data this cycle
   logic        req_ready_q, req_ready_d;
   logic        done_q,      done_d;
   logic [31:0] rdata_q,     rdata_d;
   addr_t       mem_a_q,     mem_a_d;
   logic [7:0]  mem_dout_q,  mem_dout_d;
   logic        mem_wr_q,    mem_wr_d;

   logic [1:0]  issue_nxt;

   assign issue_nxt = issue_q + 2'd1;

   always_comb begin
      // NOTE: every next-state signal defaults to its current value first, so
      // no path through the case statement can leave one unassigned (no latch).
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      last_d      = last_q;
      io_d        = io_q;
      issue_d     = issue_q;
      capture_d   = capture_q;
      addr_vld_d  = addr_vld_q;
      inflight_d  = inflight_q;
      req_ready_d = req_ready_q;
      done_d      = 1'b0;
      rdata_d     = rdata_q;
      mem_a_d     = mem_a_q;
      mem_dout_d  = mem_dout_q;
      mem_wr_d    = mem_wr_q;

      case (state_q)
         IDLE: begin
            if (!req_ready_q) begin
               // The done cycle has passed: reopen for the next request.
               req_ready_d = 1'b1;
            end else if (req_valid && rdy) begin
               req_ready_d = 1'b0;
               addr_d      = req_addr;
               wdata_d     = req_wdata;
               last_d      = last_idx(req_len);
               io_d        = (req_addr[17:16] == IO_HI);
               issue_d     = 2'd0;
               capture_d   = 2'd0;
               inflight_d  = 1'b0;
               rdata_d     = '0;
               mem_a_d     = req_addr;
               mem_dout_d  = req_wdata[7:0];
               if (req_wr) begin
                  addr_vld_d = 1'b0;
                  if ((req_addr[17:16] == IO_HI) && io_buffer_full) begin
                     state_d  = IOWAIT;
                     mem_wr_d = 1'b0;
                  end else begin
                     state_d  = WR;
                     mem_wr_d = 1'b1;
                  end
               end else begin
                  state_d    = RD;
                  mem_wr_d   = 1'b0;
                  addr_vld_d = 1'b1;
               end
            end
         end

         RD: begin
            if (!rdy) begin
               // Drop whatever is in flight and point the bus back at the
               // first uncaptured byte so it is re-presented on resume.
               issue_d    = capture_q;
               mem_a_d    = addr_q + {30'd0, capture_q};
               addr_vld_d = 1'b1;
               inflight_d = 1'b0;
            end else begin
               inflight_d = addr_vld_q;
               if (addr_vld_q) begin
                  if (issue_q != last_q) begin
                     issue_d    = issue_nxt;
                     mem_a_d    = addr_q + {30'd0, issue_nxt};
                     addr_vld_d = 1'b1;
                  end else begin
                     addr_vld_d = 1'b0;
                  end
               end
               if (inflight_q) begin
                  rdata_d[8*capture_q +: 8] = mem_din;
                  if (capture_q == last_q) begin
                     done_d     = 1'b1;
                     state_d    = IDLE;
                     addr_vld_d = 1'b0;
                     inflight_d = 1'b0;
                  end else begin
                     capture_d = capture_q + 2'd1;
                  end
               end
            end
         end

         WR: begin
            // With rdy low everything holds, so the same byte stays on the bus.
            if (rdy) begin
               if (issue_q == last_q) begin
                  done_d   = 1'b1;
                  state_d  = IDLE;
                  mem_wr_d = 1'b0;
               end else begin
                  issue_d    = issue_nxt;
                  mem_a_d    = addr_q + {30'd0, issue_nxt};
                  mem_dout_d = byte_sel(wdata_q, issue_nxt);
                  if (io_q && io_buffer_full) begin
                     // Next byte is staged on the bus but not strobed.
                     state_d  = IOWAIT;
                     mem_wr_d = 1'b0;
                  end else begin
                     mem_wr_d = 1'b1;
                  end
               end
            end
         end

         IOWAIT: begin
            if (rdy && !io_buffer_full) begin
               state_d  = WR;
               mem_wr_d = 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its pre-edge value, independent of statement order.
      if (!rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         last_q      <= '0;
         io_q        <= 1'b0;
         issue_q     <= '0;
         capture_q   <= '0;
         addr_vld_q  <= 1'b0;
         inflight_q  <= 1'b0;
         req_ready_q <= 1'b1;
         done_q      <= 1'b0;
         rdata_q     <= '0;
         mem_a_q     <= '0;
         mem_dout_q  <= '0;
         mem_wr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         last_q      <= last_d;
         io_q        <= io_d;
         issue_q     <= issue_d;
         capture_q   <= capture_d;
         addr_vld_q  <= addr_vld_d;
         inflight_q  <= inflight_d;
         req_ready_q <= req_ready_d;
         done_q      <= done_d;
         rdata_q     <= rdata_d;
         mem_a_q     <= mem_a_d;
         mem_dout_q  <= mem_dout_d;
         mem_wr_q    <= mem_wr_d;
      end
   end

   assign req_ready = req_ready_q;
   assign done      = done_q;
   assign rdata     = rdata_q;
   assign mem_a     = mem_a_q;
   assign mem_dout  = mem_dout_q;
   // A stalled cycle must never strobe the bus, even with a write staged.
   assign mem_wr    = mem_wr_q & rdy;

endmodule

// File: tb/tb_byte_bus_engine.sv
// ----------------------------------------------------------------------------
// tb_byte_bus_engine
// Directed bench for byte_bus_engine. Inputs change 1 time unit after a
// rising edge; outputs are sampled on the falling edge. "Cycle k" is the
// clock period after the k-th rising edge following the accept cycle 0.
// ----------------------------------------------------------------------------
module tb_byte_bus_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [31:0] req_addr;
   logic [2:0]  req_len;
   logic [31:0] req_wdata;
   logic        done;
   logic [31:0] rdata;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;
   int wr_snap;

   byte_bus_engine dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_wr         (req_wr),
      .req_addr       (req_addr),
      .req_len        (req_len),
      .req_wdata      (req_wdata),
      .done           (done),
      .rdata          (rdata),
      .mem_din        (mem_din),
      .mem_dout       (mem_dout),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr),
      .io_buffer_full (io_buffer_full)
   );

   always #5 clk = ~clk;

   // RAM contents: 0x100..0x103 hold 11 22 33 44, everything else is a
   // recognisable address-derived pattern.
   function automatic logic [7:0] ram_byte(input logic [31:0] a);
      case (a)
         32'h100: return 8'h11;
         32'h101: return 8'h22;
         32'h102: return 8'h33;
         32'h103: return 8'h44;
         default: return a[7:0] ^ 8'h5A;
      endcase
   endfunction

   // Synchronous RAM: the byte for the address seen in one cycle arrives
   // on mem_din in the next.
   always @(posedge clk) begin
      mem_din <= ram_byte(mem_a);
      if (mem_wr) wr_count <= wr_count + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
      checks++;
      assert (obs === expd)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expd);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b0;
      rdy            = 1'b1;
      req_valid      = 1'b0;
      req_wr         = 1'b0;
      req_addr       = '0;
      req_len        = 3'd1;
      req_wdata      = '0;
      io_buffer_full = 1'b0;

      // ---------------- reset state ----------------
      cyc(); cyc();
      smp();
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_done",      {31'd0, done},      32'd0);
      check("rst_rdata",     rdata,              32'd0);
      check("rst_mem_a",     mem_a,              32'd0);
      check("rst_mem_dout",  {24'd0, mem_dout},  32'd0);
      check("rst_mem_wr",    {31'd0, mem_wr},    32'd0);
      cyc(); rst = 1'b1;
      cyc();

      // ---------------- load word 0x100 ----------------
      cyc(); req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h100; req_len = 3'd4;
      smp(); check("lw_c0_ready", {31'd0, req_ready}, 32'd1);
      cyc(); req_valid = 1'b0;
      smp(); check("lw_c1_a", mem_a, 32'h100);
      check("lw_c1_wr", {31'd0, mem_wr}, 32'd0);
      check("lw_c1_ready", {31'd0, req_ready}, 32'd0);
      cyc(); smp(); check("lw_c2_a", mem_a, 32'h101);
      cyc(); smp(); check("lw_c3_a", mem_a, 32'h102);
      cyc(); smp(); check("lw_c4_a", mem_a, 32'h103);
      cyc(); smp(); check("lw_c5_done", {31'd0, done}, 32'd0);
      cyc(); smp(); check("lw_c6_done", {31'd0, done}, 32'd1);
      check("lw_c6_rdata", rdata, 32'h44332211);
      check("lw_c6_ready", {31'd0, req_ready}, 32'd0);
      cyc(); smp(); check("lw_c7_done", {31'd0, done}, 32'd0);
      check("lw_c7_ready", {31'd0, req_ready}, 32'd1);

      // ---------------- store half 0xABCD to 0x204 ----------------
      cyc(); req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h204; req_len = 3'd2;
      req_wdata = 32'h0000ABCD;
      cyc(); req_valid = 1'b0;
      smp(); check("sh_c1_a", mem_a, 32'h204);
      check("sh_c1_dout", {24'd0, mem_dout}, 32'hCD);
      check("sh_c1_wr", {31'd0, mem_wr}, 32'd1);
      cyc(); smp(); check("sh_c2_a", mem_a, 32'h205);
      check("sh_c2_dout", {24'd0, mem_dout}, 32'hAB);
      check("sh_c2_wr", {31'd0, mem_wr}, 32'd1);
      check("sh_c2_done", {31'd0, done}, 32'd0);
      cyc(); smp(); check("sh_c3_done", {31'd0, done}, 32'd1);
      check("sh_c3_wr", {31'd0, mem_wr}, 32'd0);
      cyc();

      // ---------------- I/O store 0x41 to 0x30000, buffer full 3 cycles ----
      cyc(); req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h30000; req_len = 3'd1;
      req_wdata = 32'h41; io_buffer_full = 1'b1;
      smp(); wr_snap = wr_count;
      cyc(); req_valid = 1'b0;
      smp(); check("io_c1_wr", {31'd0, mem_wr}, 32'd0);
      cyc(); smp(); check("io_c2_wr", {31'd0, mem_wr}, 32'd0);
      cyc(); io_buffer_full = 1'b0;
      smp(); check("io_c3_wr", {31'd0, mem_wr}, 32'd0);
      check("io_c3_done", {31'd0, done}, 32'd0);
      cyc(); smp(); check("io_c4_wr", {31'd0, mem_wr}, 32'd1);
      check("io_c4_a", mem_a, 32'h30000);
      check("io_c4_dout", {24'd0, mem_dout}, 32'h41);
      cyc(); smp(); check("io_c5_done", {31'd0, done}, 32'd1);
      check("io_c5_wr", {31'd0, mem_wr}, 32'd0);
      check("io_writes", wr_count - wr_snap, 32'd1);
      cyc();

      // ---------------- load word with rdy low in cycles 3-4 ----------------
      cyc(); req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h100; req_len = 3'd4;
      cyc(); req_valid = 1'b0;
      smp(); check("rl_c1_a", mem_a, 32'h100);
      cyc(); smp(); check("rl_c2_a", mem_a, 32'h101);
      cyc(); rdy = 1'b0;
      cyc();
      cyc(); rdy = 1'b1;
      smp(); check("rl_c5_a", mem_a, 32'h101);
      cyc(); smp(); check("rl_c6_a", mem_a, 32'h102);
      cyc(); smp(); check("rl_c7_a", mem_a, 32'h103);
      cyc(); smp(); check("rl_c8_done", {31'd0, done}, 32'd0);
      cyc(); smp(); check("rl_c9_done", {31'd0, done}, 32'd1);
      check("rl_c9_rdata", rdata, 32'h44332211);
      cyc();

      // ---------------- store half across 2^32 wrap, rdy low on byte 1 ------
      cyc(); req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'hFFFF_FFFF; req_len = 3'd2;
      req_wdata = 32'h0000_1234;
      cyc(); req_valid = 1'b0;
      smp(); check("wrap_c1_a", mem_a, 32'hFFFF_FFFF);
      check("wrap_c1_dout", {24'd0, mem_dout}, 32'h34);
      cyc(); rdy = 1'b0;
      smp(); check("wrap_c2_a", mem_a, 32'h0);
      check("wrap_c2_wr_stall", {31'd0, mem_wr}, 32'd0);
      cyc(); rdy = 1'b1;
      smp(); check("wrap_c3_a", mem_a, 32'h0);
      check("wrap_c3_dout", {24'd0, mem_dout}, 32'h12);
      check("wrap_c3_wr", {31'd0, mem_wr}, 32'd1);
      check("wrap_c3_done", {31'd0, done}, 32'd0);
      cyc(); smp(); check("wrap_c4_done", {31'd0, done}, 32'd1);
      cyc();

      // ---------------- reset in cycle 2 of a word store ----------------
      cyc(); req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h400; req_len = 3'd4;
      req_wdata = 32'hDEAD_BEEF;
      cyc(); req_valid = 1'b0;
      smp(); check("rs_c1_dout", {24'd0, mem_dout}, 32'hEF);
      cyc(); rst = 1'b0;
      cyc(); rst = 1'b1;
      smp(); wr_snap = wr_count;
      check("rs_c3_wr", {31'd0, mem_wr}, 32'd0);
      check("rs_c3_a", mem_a, 32'd0);
      check("rs_c3_dout", {24'd0, mem_dout}, 32'd0);
      check("rs_c3_done", {31'd0, done}, 32'd0);
      check("rs_c3_rdata", rdata, 32'd0);
      cyc(); smp(); check("rs_c4_ready", {31'd0, req_ready}, 32'd1);
      check("rs_c4_wr", {31'd0, mem_wr}, 32'd0);
      cyc(); cyc(); smp();
      check("rs_no_writes", wr_count - wr_snap, 32'd0);

      // ---------------- single-byte load after reset ----------------
      cyc(); req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h103; req_len = 3'd1;
      cyc(); req_valid = 1'b0;
      smp(); check("lb_c1_a", mem_a, 32'h103);
      cyc(); smp(); check("lb_c2_done", {31'd0, done}, 32'd0);
      cyc(); smp(); check("lb_c3_done", {31'd0, done}, 32'd1);
      check("lb_c3_rdata", rdata, 32'h0000_0044);

      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/byte_bus_engine.md
# byte_bus_engine

Serializes one 1-, 2- or 4-byte memory request into byte-wide cycles on the external RAM/UART bus, directly downstream of the core's memory arbitration and upstream of the pins `mem_a`/`mem_dout`/`mem_wr`/`mem_din`. It accepts one request at a time, assembles little-endian read data, and throttles I/O writes against `io_buffer_full`. It also guarantees that no write byte is repeated or dropped across `rdy` stalls.

## Interface
- `IO_HI`, default 2'b11: value of `addr[17:16]` that marks I/O space.
- `clk` input 1: system clock. One clock; reset is synchronous and active-low.
- `rst` input 1: synchronous, active-low reset.
- `rdy` input 1: global ready. Low freezes the engine.
- `req_valid` input 1: request present.
- `req_ready` output 1: engine idle, so a request is accepted this cycle.
- `req_wr` input 1: 1 = store, 0 = load.
- `req_addr` input 32: byte address of byte 0.
- `req_len` input 3: byte count, one of 1, 2 or 4. Other values are illegal.
- `req_wdata` input 32: store data, byte k = bits [8k+7:8k].
- `done` output 1: one-cycle pulse when the request completes.
- `rdata` output 32: load result, zero-extended. Valid while `done` is high.
- `mem_din` input 8: RAM read byte.
- `mem_dout` output 8: write byte.
- `mem_a` output 32: byte address.
- `mem_wr` output 1: 1 = write.
- `io_buffer_full` input 1: UART TX buffer full.

## Operation
- States: IDLE, RD, WR, IOWAIT.
- IDLE:
  - `req_ready`=1. On `req_valid&rdy`, latch addr, len, wr and wdata; clear the byte counters.
  - Go to WR, or IOWAIT if the request is a write, `addr[17:16]==IO_HI`, and `io_buffer_full`=1; otherwise RD.
- RD:
  - Presents `mem_a`=addr+i for issue index i=0..len-1, with `mem_wr`=0.
  - The byte on `mem_din` in the cycle after the address was presented is stored into `rdata[8c+7:8c]`, where c is the capture index.
  - After capture c=len-1, pulse `done` and return to IDLE.
- WR:
  - Presents `mem_a`=addr+i, `mem_dout`=wdata byte i and `mem_wr`=1, one byte per cycle.
  - After byte len-1, pulse `done` and return to IDLE.
  - For an I/O address, before each byte: if `io_buffer_full`=1, go to IOWAIT with `mem_wr`=0.
- IOWAIT: outputs `mem_wr`=0; returns to WR at the first cycle `io_buffer_full`=0.
- `rdy`=0 in any state:
  - State and counters hold; `mem_wr` forced 0.
  - Read data arriving in that cycle is discarded.
  - On resume, RD re-presents the address of the first uncaptured byte, so the issue index is rewound to the capture index.
  - WR re-presents the same unwritten byte.
- Address arithmetic is 32-bit and wraps modulo 2^32. No alignment check.
- Reads from I/O space must be single-byte. The engine does not enforce this.
- Reset outputs:
  - `req_ready`=1, `done`=0, `rdata`=0.
  - `mem_a`=0, `mem_dout`=0, `mem_wr`=0.
  - State IDLE.
- Reset mid-request abandons the request with no further bus writes.

## Timing
- Bus outputs are registered. Cycle 0 is the accept cycle.
- Read of N bytes:
  - Addresses appear in cycles 1..N.
  - Data is captured at the end of cycles 2..N+1.
  - `done` and `rdata` are high in cycle N+2. Latency is N+2.
- Write of N bytes:
  - Bytes appear in cycles 1..N.
  - `done` is high in cycle N+1. Latency is N+1, plus one cycle per IOWAIT or `rdy`-low cycle.
- `req_ready` is 0 from cycle 1 until the cycle after `done`.
- A new request is accepted no earlier than the cycle after `done` (back-to-back gap 0 idle cycles beyond that).
- `io_buffer_full` is sampled in the cycle before each I/O byte would be driven.

## Structure
- Shared package `mem_bus_pkg`:
  - state enum (IDLE/RD/WR/IOWAIT)
  - `IO_HI`
  - length encodings LEN_B=1, LEN_H=2, LEN_W=4
  - 32-bit address type
- No sub-module is needed. This is a single FSM with two 2-bit counters (issue index, capture index).

## Test plan
- Load word: addr 0x100 holding bytes 11 22 33 44. Response: `mem_a` 0x100..0x103 in cycles 1–4; `done` in cycle 6 with `rdata`=0x44332211.
- Store half: wdata 0xABCD to 0x204. Response: cycle 1 `mem_a`=0x204, `mem_dout`=0xCD, `mem_wr`=1; cycle 2 0x205/0xAB; `done` in cycle 3.
- I/O store: byte 0x41 to 0x30000 with `io_buffer_full`=1 for 3 cycles. Response: `mem_wr`=0 throughout the wait, exactly one write of 0x41, `done` 3 cycles late.
- `rdy` low for 2 cycles during the second byte of a word load. Response: address 0x101 is re-presented after resume, `rdata` is still correct, and `done` is delayed by 2+1 cycles.
- `rst`=0 in cycle 2 of a word store. Response: no `mem_wr` afterwards, all outputs at reset values, and `req_ready`=1 the cycle after reset deasserts.
